// File: rtl/fir_tcdm_arbiter_pkg.sv
// fir_package: shared FIR TCDM arbiter defaults (port count, outstanding depth) and port-index type
package fir_package;
  localparam int FIR_TCDM_MP = 4;
  localparam int FIR_TCDM_OUT_DEPTH = 4;
  typedef logic [$clog2(FIR_TCDM_MP)-1:0] fir_port_idx_t;
endpackage

// File: rtl/fir_tcdm_id_fifo.sv
// fir_tcdm_id_fifo: in-order port-ID FIFO; in clk_i rst_i i_push i_data i_pop, out o_data(head) o_full o_empty o_count
module fir_tcdm_id_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (PW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_data = r_mem[r_rd];
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & ~o_empty;
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
endmodule

// File: rtl/fir_tcdm_arbiter.sv
// fir_tcdm_arbiter: round-robin MP-to-1 TCDM arbiter; in_* upstream req/gnt/resp, out_* bank req/gnt/resp, outstanding_o count, err_o sticky
module fir_tcdm_arbiter
  import fir_package::*;
#(
  parameter int MP = FIR_TCDM_MP,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int OUT_DEPTH = FIR_TCDM_OUT_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [MP-1:0]              in_req_i,
  output logic [MP-1:0]              in_gnt_o,
  input  logic [MP*AW-1:0]           in_add_i,
  input  logic [MP-1:0]              in_wen_i,
  input  logic [MP*(DW/8)-1:0]       in_be_i,
  input  logic [MP*DW-1:0]           in_data_i,
  output logic [MP*DW-1:0]           in_r_data_o,
  output logic [MP-1:0]              in_r_valid_o,
  output logic                       out_req_o,
  input  logic                       out_gnt_i,
  output logic [AW-1:0]              out_add_o,
  output logic                       out_wen_o,
  output logic [DW/8-1:0]            out_be_o,
  output logic [DW-1:0]              out_data_o,
  input  logic [DW-1:0]              out_r_data_i,
  input  logic                       out_r_valid_i,
  output logic [$clog2(OUT_DEPTH):0] outstanding_o,
  output logic                       err_o
);
  localparam int IW = $clog2(MP);
  localparam int BW = DW / 8;
  logic [IW-1:0] r_rr, w_sel, w_idx, w_head;
  logic w_hs, w_full, w_empty, w_pop, r_err;
  always_comb begin
    w_sel = r_rr;
    w_idx = '0;
    for (int i = MP - 1; i >= 0; i--) begin
      w_idx = IW'((int'(r_rr) + i) % MP);
      if (in_req_i[w_idx]) w_sel = w_idx;
    end
  end
  always_comb begin
    out_add_o = '0;
    out_wen_o = 1'b0;
    out_be_o = '0;
    out_data_o = '0;
    for (int i = 0; i < MP; i++)
      if (w_sel == IW'(i)) begin
        out_add_o = in_add_i[i*AW +: AW];
        out_wen_o = in_wen_i[i];
        out_be_o = in_be_i[i*BW +: BW];
        out_data_o = in_data_i[i*DW +: DW];
      end
  end
  assign out_req_o = |in_req_i & ~w_full & ~rst_i;
  assign w_hs = out_req_o & out_gnt_i;
  assign in_gnt_o = w_hs ? (MP'(1) << w_sel) : '0;
  assign w_pop = out_r_valid_i & ~w_empty;
  assign in_r_valid_o = w_pop ? (MP'(1) << w_head) : '0;
  assign in_r_data_o = {MP{out_r_data_i}};
  assign err_o = r_err;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_rr <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_hs) r_rr <= (w_sel == IW'(MP - 1)) ? '0 : w_sel + 1'b1;
      r_err <= r_err | (out_r_valid_i & w_empty);
    end
  fir_tcdm_id_fifo #(
    .W(IW),
    .DEPTH(OUT_DEPTH)
  ) u_id_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .i_push(w_hs),
    .i_data(w_sel),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(outstanding_o)
  );
endmodule

// File: tb/tb_fir_tcdm_arbiter.sv
// tb_fir_tcdm_arbiter: scoreboard bench for fir_tcdm_arbiter with directed vectors
module tb_fir_tcdm_arbiter;
  localparam int MP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [MP-1:0] in_req, in_gnt, in_wen, in_r_valid;
  logic [MP*AW-1:0] in_add;
  logic [MP*BW-1:0] in_be;
  logic [MP*DW-1:0] in_data, in_r_data;
  logic out_req, out_gnt, out_wen, out_r_valid, err;
  logic [AW-1:0] out_add;
  logic [BW-1:0] out_be;
  logic [DW-1:0] out_data, out_r_data;
  logic [2:0] outstanding;
  logic [AW-1:0] p_add [MP];
  logic p_wen [MP];
  logic [BW-1:0] p_be [MP];
  logic [DW-1:0] p_data [MP];
  typedef struct {int port; logic [AW-1:0] add; logic wen; logic [BW-1:0] be; logic [DW-1:0] data;} gnt_t;
  typedef struct {int port; logic [DW-1:0] data;} rsp_t;
  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  int checks = 0;
  int failures = 0;
  fir_tcdm_arbiter #(.MP(MP), .AW(AW), .DW(DW), .OUT_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
    .in_be_i(in_be), .in_data_i(in_data), .in_r_data_o(in_r_data), .in_r_valid_o(in_r_valid),
    .out_req_o(out_req), .out_gnt_i(out_gnt), .out_add_o(out_add), .out_wen_o(out_wen),
    .out_be_o(out_be), .out_data_o(out_data), .out_r_data_i(out_r_data), .out_r_valid_i(out_r_valid),
    .outstanding_o(outstanding), .err_o(err)
  );
  always_comb begin
    in_add = '0;
    in_wen = '0;
    in_be = '0;
    in_data = '0;
    for (int p = 0; p < MP; p++) begin
      in_add[p*AW +: AW] = p_add[p];
      in_wen[p] = p_wen[p];
      in_be[p*BW +: BW] = p_be[p];
      in_data[p*DW +: DW] = p_data[p];
    end
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_g(input int p);
    exp_gnt.push_back('{p, p_add[p], p_wen[p], p_be[p], p_data[p]});
  endtask
  task automatic exp_r(input int p, input logic [DW-1:0] d);
    exp_rsp.push_back('{p, d});
  endtask
  always @(negedge clk) begin
    gnt_t g;
    rsp_t r;
    if (in_gnt != '0) begin
      if (exp_gnt.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant got=%b exp=none", in_gnt);
      end else begin
        g = exp_gnt.pop_front();
        chk("grant_onehot", in_gnt, 64'(1) << g.port);
        chk("grant_add", out_add, g.add);
        chk("grant_wen", out_wen, g.wen);
        chk("grant_be", out_be, g.be);
        chk("grant_data", out_data, g.data);
      end
    end
    if (in_r_valid != '0) begin
      if (exp_rsp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid got=%b exp=none", in_r_valid);
      end else begin
        r = exp_rsp.pop_front();
        chk("rvalid_onehot", in_r_valid, 64'(1) << r.port);
        chk("rdata_lane", in_r_data[r.port*DW +: DW], r.data);
      end
    end
  end
  initial begin
    for (int p = 0; p < MP; p++) begin
      p_add[p] = 32'h1000 + 32'(p * 16);
      p_wen[p] = p[0];
      p_be[p] = BW'(p + 1);
      p_data[p] = 32'hC0DE_0000 + 32'(p);
    end
    in_req = '1;
    out_gnt = 1'b1;
    out_r_valid = 1'b1;
    out_r_data = '0;
    #1;
    chk("rst_out_req", out_req, 0);
    chk("rst_gnt", in_gnt, 0);
    chk("rst_rvalid", in_r_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    in_req = '0;
    out_r_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      in_req = (k < 8) ? '1 : '0;
      out_r_valid = k >= 1;
      out_r_data = 32'hA000_0000 + 32'(k);
      if (k < 8) exp_g(k % 4);
      if (k >= 1) exp_r((k - 1) % 4, 32'hA000_0000 + 32'(k));
      #1;
      if (k >= 1) chk("rr_outstanding", outstanding, 1);
      tick();
    end
    in_req = '0;
    out_r_valid = 1'b0;
    #1 chk("rr_drained", outstanding, 0);
    p_add[2] = 32'h100;
    p_wen[2] = 1'b1;
    in_req = 4'b0100;
    exp_g(2);
    tick();
    in_req = '0;
    for (int k = 1; k <= 3; k++) begin
      out_r_valid = k == 3;
      out_r_data = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
      if (k == 3) exp_r(2, 32'hDEAD_BEEF);
      #1 chk("single_outstanding", outstanding, 1);
      tick();
    end
    out_r_valid = 1'b0;
    #1 chk("single_drained", outstanding, 0);
    in_req = '1;
    for (int k = 0; k < 4; k++) begin
      exp_g((3 + k) % 4);
      #1 chk("fill_outstanding", outstanding, 64'(k));
      tick();
    end
    #1;
    chk("full_req_low", out_req, 0);
    chk("full_outstanding", outstanding, 4);
    tick();
    out_r_valid = 1'b1;
    out_r_data = 32'h5000_0003;
    exp_r(3, 32'h5000_0003);
    #1 chk("full_pop_req_low", out_req, 0);
    tick();
    out_r_valid = 1'b0;
    exp_g(3);
    #1;
    chk("resume_req", out_req, 1);
    chk("resume_outstanding", outstanding, 3);
    tick();
    in_req = '0;
    for (int k = 0; k < 4; k++) begin
      out_r_valid = 1'b1;
      out_r_data = 32'h5100_0000 + 32'(k);
      exp_r(k, 32'h5100_0000 + 32'(k));
      #1 chk("drain_outstanding", outstanding, 64'(4 - k));
      tick();
    end
    out_r_valid = 1'b0;
    #1 chk("drain_done", outstanding, 0);
    out_gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_req = (k < 2) ? 4'b1011 : 4'b1010;
      #1 chk("stall_req", out_req, 1);
      tick();
    end
    in_req = 4'b1010;
    out_gnt = 1'b1;
    exp_g(1);
    tick();
    exp_g(3);
    tick();
    in_req = '0;
    out_r_valid = 1'b1;
    out_r_data = 32'h6000_0001;
    exp_r(1, 32'h6000_0001);
    tick();
    out_r_data = 32'h6000_0003;
    exp_r(3, 32'h6000_0003);
    tick();
    out_r_valid = 1'b0;
    #1;
    chk("stall_drained", outstanding, 0);
    chk("err_clear", err, 0);
    out_r_valid = 1'b1;
    out_r_data = 32'hBAD0_0000;
    tick();
    out_r_valid = 1'b0;
    #1 chk("spurious_err", err, 1);
    tick();
    tick();
    chk("spurious_err_sticky", err, 1);
    chk("spurious_outstanding", outstanding, 0);
    rst = 1'b1;
    #1 chk("err_reset", err, 0);
    tick();
    rst = 1'b0;
    in_req = '1;
    for (int k = 0; k < 3; k++) begin
      exp_g(k);
      tick();
    end
    #1 chk("pre_rst_outstanding", outstanding, 3);
    rst = 1'b1;
    out_r_valid = 1'b1;
    out_r_data = 32'h7000_0000;
    #1;
    chk("midrst_out_req", out_req, 0);
    chk("midrst_gnt", in_gnt, 0);
    chk("midrst_rvalid", in_r_valid, 0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_err", err, 0);
    tick();
    chk("midrst_err_hold", err, 0);
    rst = 1'b0;
    in_req = '0;
    tick();
    #1 chk("late_rsp_err", err, 1);
    tick();
    tick();
    out_r_valid = 1'b0;
    #1;
    chk("late_err_sticky", err, 1);
    chk("late_outstanding", outstanding, 0);
    tick();
    chk("gnt_queue_empty", exp_gnt.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
